// File: rtl/dual_memory_burst_if.sv
// dual_memory_burst_if -- bus bundle for dual_memory_burst.
// Carries the port A full-row signals (En_A, w_A, addrA, dinA, doutA) and
// the port B DWord burst signals (command, write stream, read stream, status).
// modport slave  : memory side (dual_memory_burst).
// modport master : host / packet-engine side.
interface dual_memory_burst_if #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 8
);
  localparam int CW         = $clog2(NUM_COL);
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;
  localparam int DW_ADDR    = ADDR_WIDTH + CW;

  // Port A
  logic                  En_A;
  logic [NUM_COL-1:0]    w_A;
  logic [ADDR_WIDTH-1:0] addrA;
  logic [DATA_WIDTH-1:0] dinA;
  logic [DATA_WIDTH-1:0] doutA;

  // Port B
  logic                  B_start;
  logic                  B_wr;
  logic [DW_ADDR-1:0]    B_addr;
  logic [LEN_WIDTH-1:0]  B_len;
  logic [COL_WIDTH-1:0]  B_din;
  logic                  B_din_valid;
  logic                  B_din_ready;
  logic [COL_WIDTH-1:0]  B_dout;
  logic                  B_dout_valid;
  logic                  B_dout_ready;
  logic                  B_busy;
  logic                  B_done;

  modport slave (
    input  En_A, w_A, addrA, dinA,
    input  B_start, B_wr, B_addr, B_len, B_din, B_din_valid, B_dout_ready,
    output doutA,
    output B_din_ready, B_dout, B_dout_valid, B_busy, B_done
  );

  modport master (
    output En_A, w_A, addrA, dinA,
    output B_start, B_wr, B_addr, B_len, B_din, B_din_valid, B_dout_ready,
    input  doutA,
    input  B_din_ready, B_dout, B_dout_valid, B_busy, B_done
  );
endinterface

// File: rtl/dual_memory_burst.sv
// dual_memory_burst -- mixed-width dual-port DWord memory with a burst engine.
// Ports:
//   clk    : clock, rising edge.
//   rst_n  : asynchronous active-low reset (array contents not reset).
//   bus    : dual_memory_burst_if.slave
//            port A: full-row access, per-column write enables, registered
//                    read-first row read (doutA).
//            port B: one B_start moves B_len consecutive DWords from B_addr
//                    ({row, col}) with valid/ready streams; pointer wraps
//                    modulo the whole array.
//   collision (only with `define COLLISION_FLAG_EN): sticky flag set when
//            A and B write the same DWord on one edge; cleared by reset or
//            an accepted B_start.
// Same-DWord write collision: port A wins; the B beat still counts.
module dual_memory_burst #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  dual_memory_burst_if.slave      bus
`ifdef COLLISION_FLAG_EN
  ,
  output logic                    collision
`endif
);
  localparam int CW      = $clog2(NUM_COL);
  localparam int DW_ADDR = ADDR_WIDTH + CW;
  localparam int DEPTH   = 2 ** ADDR_WIDTH;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                           state;
  logic [DW_ADDR-1:0]                   ptr;
  logic [LEN_WIDTH-1:0]                 rem;
  logic [COL_WIDTH-1:0]                 dout_q;
  logic                                 dout_valid_q;
  logic [NUM_COL*COL_WIDTH-1:0]         douta_q;
  logic [NUM_COL-1:0][COL_WIDTH-1:0]    mem [DEPTH];

  logic [ADDR_WIDTH-1:0]                ptr_row;
  logic [CW-1:0]                        ptr_col;
  logic                                 b_wr_beat;
  logic                                 b_rd_load;

  assign ptr_row   = ptr[DW_ADDR-1:CW];
  assign ptr_col   = ptr[CW-1:0];
  assign b_wr_beat = (state == WRITE) && bus.B_din_valid;
  // Load the output register when it is empty or being drained this cycle.
  assign b_rd_load = (state == READ) && (rem != '0) &&
                     (!dout_valid_q || bus.B_dout_ready);

  assign bus.doutA        = douta_q;
  assign bus.B_dout       = dout_q;
  assign bus.B_dout_valid = dout_valid_q;
  assign bus.B_din_ready  = (state == WRITE);
  assign bus.B_busy       = (state == WRITE) || (state == READ);
  assign bus.B_done       = (state == DONE);

  // Array writes. Port A is applied after port B so it wins a same-DWord
  // collision.
  always_ff @(posedge clk) begin
    if (b_wr_beat)
      mem[ptr_row][ptr_col] <= bus.B_din;
    if (bus.En_A) begin
      for (int unsigned c = 0; c < NUM_COL; c++) begin
        if (bus.w_A[c])
          mem[bus.addrA][c] <= bus.dinA[c*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // Port A registered read-first row read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      douta_q <= '0;
    else if (bus.En_A)
      douta_q <= mem[bus.addrA];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= '0;
      rem          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.B_start) begin
            ptr <= bus.B_addr;
            rem <= bus.B_len;
            if (bus.B_len == '0)
              state <= DONE;
            else
              state <= bus.B_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.B_din_valid) begin
            ptr <= ptr + DW_ADDR'(1);
            rem <= rem - LEN_WIDTH'(1);
            if (rem == LEN_WIDTH'(1))
              state <= DONE;
          end
        end
        READ: begin
          if (b_rd_load) begin
            dout_q       <= mem[ptr_row][ptr_col];
            dout_valid_q <= 1'b1;
            ptr          <= ptr + DW_ADDR'(1);
            rem          <= rem - LEN_WIDTH'(1);
          end else if (bus.B_dout_ready) begin
            // Reaching here with ready high means rem is already 0.
            dout_valid_q <= 1'b0;
            if (dout_valid_q)
              state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COLLISION_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      collision <= 1'b0;
    else if ((state == IDLE) && bus.B_start)
      collision <= 1'b0;
    else if (b_wr_beat && bus.En_A && bus.w_A[ptr_col] && (bus.addrA == ptr_row))
      collision <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dual_memory_burst.sv
// tb_dual_memory_burst -- directed self-checking bench for dual_memory_burst.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Build with +define+COLLISION_FLAG_EN to also exercise the collision flag.
module tb_dual_memory_burst;
  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

`ifdef COLLISION_FLAG_EN
  logic collision;
`endif

  dual_memory_burst_if #(.NUM_COL(4), .COL_WIDTH(32), .ADDR_WIDTH(6), .LEN_WIDTH(8)) bus ();

  dual_memory_burst #(.NUM_COL(4), .COL_WIDTH(32), .ADDR_WIDTH(6), .LEN_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef COLLISION_FLAG_EN
    ,
    .collision (collision)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic wr, input logic [7:0] addr, input logic [7:0] len);
    bus.B_start = 1'b1;
    bus.B_wr    = wr;
    bus.B_addr  = addr;
    bus.B_len   = len;
    tick();
    bus.B_start = 1'b0;
  endtask

  task automatic read_row(input logic [5:0] row);
    bus.En_A  = 1'b1;
    bus.w_A   = 4'b0000;
    bus.addrA = row;
    tick();
    bus.En_A  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.En_A = 1'b0; bus.w_A = '0; bus.addrA = '0; bus.dinA = '0;
    bus.B_start = 1'b0; bus.B_wr = 1'b0; bus.B_addr = '0; bus.B_len = '0;
    bus.B_din = '0; bus.B_din_valid = 1'b0; bus.B_dout_ready = 1'b0;
    tick(); tick();
    total++; if (bus.doutA !== '0) $display("FAIL rst_doutA got=%h exp=0", bus.doutA); else passed++;
    total++; if (bus.B_dout !== '0) $display("FAIL rst_B_dout got=%h exp=0", bus.B_dout); else passed++;
    total++; if (bus.B_dout_valid !== 1'b0) $display("FAIL rst_dout_valid got=%b exp=0", bus.B_dout_valid); else passed++;
    total++; if (bus.B_din_ready !== 1'b0) $display("FAIL rst_din_ready got=%b exp=0", bus.B_din_ready); else passed++;
    total++; if (bus.B_busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", bus.B_busy); else passed++;
    total++; if (bus.B_done !== 1'b0) $display("FAIL rst_done got=%b exp=0", bus.B_done); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_port_a();
    for (int i = 0; i < 4; i++) begin
      bus.En_A  = 1'b1;
      bus.w_A   = 4'b0001 << i;
      bus.addrA = 6'd0;
      bus.dinA  = {32'h4, 32'h3, 32'h2, 32'h1};
      tick();
    end
    bus.w_A = 4'b0000;
    tick();
    total++; if (bus.doutA !== 128'h00000004_00000003_00000002_00000001)
      $display("FAIL porta_row0 got=%h exp=00000004000000030000000200000001", bus.doutA); else passed++;
    bus.En_A = 1'b0; bus.addrA = 6'd1;
    tick();
    total++; if (bus.doutA !== 128'h00000004_00000003_00000002_00000001)
      $display("FAIL porta_hold got=%h exp=00000004000000030000000200000001", bus.doutA); else passed++;
    // Write col 0 while reading the same row: read returns the old row.
    bus.En_A = 1'b1; bus.w_A = 4'b0001; bus.addrA = 6'd0; bus.dinA = {96'h0, 32'h55};
    tick();
    bus.En_A = 1'b0; bus.w_A = 4'b0000;
    total++; if (bus.doutA !== 128'h00000004_00000003_00000002_00000001)
      $display("FAIL porta_read_first got=%h exp=00000004000000030000000200000001", bus.doutA); else passed++;
    read_row(6'd0);
    total++; if (bus.doutA[31:0] !== 32'h55) $display("FAIL porta_col0_new got=%h exp=00000055", bus.doutA[31:0]); else passed++;
  endtask

  task automatic test_write_burst();
    start_burst(1'b1, 8'd6, 8'd4);
    total++; if (bus.B_busy !== 1'b1) $display("FAIL wr_busy got=%b exp=1", bus.B_busy); else passed++;
    total++; if (bus.B_din_ready !== 1'b1) $display("FAIL wr_ready got=%b exp=1", bus.B_din_ready); else passed++;
    bus.B_din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.B_din = 32'hA0 + 32'(i);
      tick();
    end
    bus.B_din_valid = 1'b0;
    total++; if (bus.B_done !== 1'b1) $display("FAIL wr_done got=%b exp=1", bus.B_done); else passed++;
    total++; if (bus.B_busy !== 1'b0) $display("FAIL wr_done_busy got=%b exp=0", bus.B_busy); else passed++;
    total++; if (bus.B_din_ready !== 1'b0) $display("FAIL wr_ready_drop got=%b exp=0", bus.B_din_ready); else passed++;
    tick();
    total++; if (bus.B_done !== 1'b0) $display("FAIL wr_done_single got=%b exp=0", bus.B_done); else passed++;
    read_row(6'd1);
    total++; if (bus.doutA[127:64] !== {32'hA1, 32'hA0}) $display("FAIL wr_row1 got=%h exp=000000a1000000a0", bus.doutA[127:64]); else passed++;
    read_row(6'd2);
    total++; if (bus.doutA[63:0] !== {32'hA3, 32'hA2}) $display("FAIL wr_row2 got=%h exp=000000a3000000a2", bus.doutA[63:0]); else passed++;
  endtask

  task automatic test_read_burst();
    int          got = 0;
    int          dones = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    bus.B_dout_ready = 1'b0;
    start_burst(1'b0, 8'd6, 8'd4);
    for (int k = 0; k < 40 && dones == 0; k++) begin
      bus.B_dout_ready = (k % 2 == 0);
      if (prev_hold) begin
        total++; if (bus.B_dout_valid !== 1'b1 || bus.B_dout !== prev_data)
          $display("FAIL rd_stable got=%b/%h exp=1/%h", bus.B_dout_valid, bus.B_dout, prev_data); else passed++;
      end
      if (bus.B_dout_valid && bus.B_dout_ready) begin
        total++; if (bus.B_dout !== 32'hA0 + 32'(got))
          $display("FAIL rd_data got=%h exp=%h", bus.B_dout, 32'hA0 + 32'(got)); else passed++;
        got++;
      end
      prev_hold = bus.B_dout_valid && !bus.B_dout_ready;
      prev_data = bus.B_dout;
      tick();
      if (bus.B_done) begin
        dones++;
        total++; if (bus.B_busy !== 1'b0) $display("FAIL rd_busy_fall got=%b exp=0", bus.B_busy); else passed++;
      end
    end
    bus.B_dout_ready = 1'b0;
    total++; if (got !== 4) $display("FAIL rd_beats got=%0d exp=4", got); else passed++;
    total++; if (dones !== 1) $display("FAIL rd_done got=%0d exp=1", dones); else passed++;
    tick();
    total++; if (bus.B_done !== 1'b0 || bus.B_dout_valid !== 1'b0)
      $display("FAIL rd_idle got=%b/%b exp=0/0", bus.B_done, bus.B_dout_valid); else passed++;
  endtask

  task automatic test_wrap();
    start_burst(1'b1, 8'hFF, 8'd2);
    bus.B_din_valid = 1'b1;
    bus.B_din = 32'h11; tick();
    bus.B_din = 32'h22; tick();
    bus.B_din_valid = 1'b0;
    total++; if (bus.B_done !== 1'b1) $display("FAIL wrap_done got=%b exp=1", bus.B_done); else passed++;
    tick();
    read_row(6'd63);
    total++; if (bus.doutA[127:96] !== 32'h11) $display("FAIL wrap_row63 got=%h exp=00000011", bus.doutA[127:96]); else passed++;
    read_row(6'd0);
    total++; if (bus.doutA[31:0] !== 32'h22) $display("FAIL wrap_row0 got=%h exp=00000022", bus.doutA[31:0]); else passed++;
  endtask

  task automatic test_collision();
    // A and B write row 5 col 1 on the same edge; A also seeds col 2.
    start_burst(1'b1, 8'd21, 8'd1);
    bus.En_A = 1'b1; bus.w_A = 4'b0110; bus.addrA = 6'd5;
    bus.dinA = {32'h0, 32'h12345678, 32'hAAAAAAAA, 32'h0};
    bus.B_din_valid = 1'b1; bus.B_din = 32'hBBBBBBBB;
    tick();
    bus.En_A = 1'b0; bus.w_A = 4'b0000; bus.B_din_valid = 1'b0;
    total++; if (bus.B_done !== 1'b1) $display("FAIL coll_beat_done got=%b exp=1", bus.B_done); else passed++;
`ifdef COLLISION_FLAG_EN
    total++; if (collision !== 1'b1) $display("FAIL coll_flag_set got=%b exp=1", collision); else passed++;
`endif
    tick();
`ifdef COLLISION_FLAG_EN
    total++; if (collision !== 1'b1) $display("FAIL coll_flag_sticky got=%b exp=1", collision); else passed++;
`endif
    read_row(6'd5);
    total++; if (bus.doutA[63:32] !== 32'hAAAAAAAA) $display("FAIL coll_a_wins got=%h exp=aaaaaaaa", bus.doutA[63:32]); else passed++;
    // B writes row 5 col 2 while A reads row 5: A sees the old data.
    start_burst(1'b1, 8'd22, 8'd1);
    bus.En_A = 1'b1; bus.w_A = 4'b0000; bus.addrA = 6'd5;
    bus.B_din_valid = 1'b1; bus.B_din = 32'hCC;
    tick();
    bus.En_A = 1'b0; bus.B_din_valid = 1'b0;
    total++; if (bus.doutA[95:64] !== 32'h12345678) $display("FAIL coll_bwr_aread got=%h exp=12345678", bus.doutA[95:64]); else passed++;
`ifdef COLLISION_FLAG_EN
    total++; if (collision !== 1'b0) $display("FAIL coll_flag_clear got=%b exp=0", collision); else passed++;
`endif
    tick();
    read_row(6'd5);
    total++; if (bus.doutA[95:64] !== 32'hCC) $display("FAIL coll_b_written got=%h exp=000000cc", bus.doutA[95:64]); else passed++;
    // A writes row 5 col 2 on the edge B reads it: B sees the old data.
    start_burst(1'b0, 8'd22, 8'd1);
    bus.En_A = 1'b1; bus.w_A = 4'b0100; bus.addrA = 6'd5;
    bus.dinA = {32'h0, 32'hEE, 64'h0};
    bus.B_dout_ready = 1'b0;
    tick();
    bus.En_A = 1'b0; bus.w_A = 4'b0000;
    total++; if (bus.B_dout_valid !== 1'b1 || bus.B_dout !== 32'hCC)
      $display("FAIL coll_awr_bread got=%b/%h exp=1/000000cc", bus.B_dout_valid, bus.B_dout); else passed++;
    bus.B_dout_ready = 1'b1;
    tick();
    bus.B_dout_ready = 1'b0;
    total++; if (bus.B_done !== 1'b1) $display("FAIL coll_rd_done got=%b exp=1", bus.B_done); else passed++;
    tick();
    read_row(6'd5);
    total++; if (bus.doutA[95:64] !== 32'hEE) $display("FAIL coll_a_written got=%h exp=000000ee", bus.doutA[95:64]); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    bus.En_A = 1'b1; bus.w_A = 4'b1111; bus.addrA = 6'd10; bus.dinA = '0;
    tick();
    bus.En_A = 1'b0; bus.w_A = 4'b0000;
    read_row(6'd5);   // leaves doutA non-zero before the reset
    start_burst(1'b1, 8'd40, 8'd4);
    bus.B_din_valid = 1'b1;
    bus.B_din = 32'hD0; tick();
    bus.B_din = 32'hD1; tick();
    rst_n = 1'b0;
    #1;
    total++; if (bus.doutA !== '0) $display("FAIL mrst_doutA got=%h exp=0", bus.doutA); else passed++;
    total++; if (bus.B_dout !== '0) $display("FAIL mrst_B_dout got=%h exp=0", bus.B_dout); else passed++;
    total++; if (bus.B_din_ready !== 1'b0 || bus.B_busy !== 1'b0 || bus.B_done !== 1'b0 || bus.B_dout_valid !== 1'b0)
      $display("FAIL mrst_status got=%b%b%b%b exp=0000", bus.B_din_ready, bus.B_busy, bus.B_done, bus.B_dout_valid); else passed++;
    bus.B_din_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.B_done !== 1'b0 || bus.B_busy !== 1'b0)
      $display("FAIL mrst_no_done got=%b/%b exp=0/0", bus.B_done, bus.B_busy); else passed++;
    read_row(6'd10);
    total++; if (bus.doutA !== {32'h0, 32'h0, 32'hD1, 32'hD0})
      $display("FAIL mrst_partial got=%h exp=0000000000000000000000d1000000d0", bus.doutA); else passed++;
    // Zero-length command: straight to DONE, no array access.
    bus.B_din_valid = 1'b1; bus.B_din = 32'hFFFFFFFF;
    start_burst(1'b1, 8'd40, 8'd0);
    total++; if (bus.B_done !== 1'b1 || bus.B_busy !== 1'b0 || bus.B_din_ready !== 1'b0)
      $display("FAIL len0_done got=%b%b%b exp=100", bus.B_done, bus.B_busy, bus.B_din_ready); else passed++;
    bus.B_din_valid = 1'b0;
    tick();
    total++; if (bus.B_done !== 1'b0) $display("FAIL len0_single got=%b exp=0", bus.B_done); else passed++;
    read_row(6'd10);
    total++; if (bus.doutA !== {32'h0, 32'h0, 32'hD1, 32'hD0})
      $display("FAIL len0_nowrite got=%h exp=0000000000000000000000d1000000d0", bus.doutA); else passed++;
  endtask

  initial begin
    test_reset();
    test_port_a();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_collision();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
